// File: rtl/sequential_divider_128bit.sv
// Radix-2 restoring sequential divider: one quotient bit per clock, start/done
// handshake, registered results and observable state/count.

module sequential_divider_step #(
  parameter int N = 128
) (
  input  logic [N:0]   rem_i,
  input  logic [N-1:0] quo_i,
  input  logic [N-1:0] div_i,
  output logic [N:0]   rem_o,
  output logic [N-1:0] quo_o
);
  logic [N+1:0] shifted;
  logic [N+1:0] diff;

  // One extra guard bit above the shifted remainder makes the borrow the sign.
  always_comb begin
    shifted = {1'b0, rem_i[N-1:0], quo_i[N-1]};
    diff    = shifted - {2'b00, div_i};
    rem_o   = diff[N+1] ? shifted[N:0] : diff[N:0];
    quo_o   = {quo_i[N-2:0], ~diff[N+1]};
  end
endmodule

module sequential_divider_128bit #(
  parameter int N  = 128,
  parameter int CW = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  output logic [N-1:0]  q,
  output logic [N-1:0]  r,
  output logic          done,
  output logic          busy,
  output logic          div_by_zero,
  output logic [1:0]    state_out,
  output logic [CW-1:0] count_out
);
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N:0]    rem_q, rem_d;
  logic [N-1:0]  quo_q, quo_d;
  logic [N-1:0]  div_q, div_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zdiv_q, zdiv_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  r_q, r_d;
  logic          dbz_q, dbz_d;

  logic [N:0]    step_rem;
  logic [N-1:0]  step_quo;

  sequential_divider_step #(.N(N)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (div_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    zdiv_d  = zdiv_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          quo_d   = a;
          div_d   = b;
          rem_d   = '0;
          dbz_d   = 1'b0;
          // A zero divisor takes a single non-iterating RUN cycle so done
          // still lands one edge after the start edge.
          zdiv_d  = (b == '0);
          cnt_d   = (b == '0) ? '0 : CW'(N - 1);
        end
      end
      S_RUN: begin
        if (!zdiv_q) begin
          rem_d = step_rem;
          quo_d = step_quo;
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
          zdiv_d  = 1'b0;
          if (zdiv_q) begin
            q_d   = '1;
            r_d   = quo_q;
            dbz_d = 1'b1;
          end else begin
            q_d   = step_quo;
            r_d   = step_rem[N-1:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      zdiv_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      zdiv_q  <= zdiv_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  assign q           = q_q;
  assign r           = r_q;
  assign div_by_zero = dbz_q;
  assign done        = (state_q == S_DONE);
  assign busy        = (state_q == S_RUN);
  assign state_out   = state_q;
  assign count_out   = cnt_q;
endmodule

// File: tb/tb_sequential_divider_128bit.sv
// Self-checking bench: 128-bit and 8-bit divider instances against a plain
// arithmetic reference (a/b, a%b, all-ones/a on zero divisor).

module tb_sequential_divider_128bit;
  localparam int N = 128;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [N-1:0]   a, b, q, r;
  logic           done, busy, dbz;
  logic [1:0]     state_out;
  logic [6:0]     count_out;

  logic           start8;
  logic [7:0]     a8, b8, q8, r8;
  logic           done8, busy8, dbz8;
  logic [1:0]     state8;
  logic [2:0]     count8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sequential_divider_128bit #(.N(N), .CW(7)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .q(q), .r(r),
    .done(done), .busy(busy), .div_by_zero(dbz), .state_out(state_out),
    .count_out(count_out)
  );

  sequential_divider_128bit #(.N(8), .CW(3)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .q(q8), .r(r8),
    .done(done8), .busy(busy8), .div_by_zero(dbz8), .state_out(state8),
    .count_out(count8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Pulses start for one edge (edge 0) and waits for done; cyc = edges after edge 0.
  task automatic do_op128(input logic [N-1:0] av, input logic [N-1:0] bv, output int cyc);
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_op8(input logic [7:0] av, input logic [7:0] bv, output int cyc);
    a8 = av; b8 = bv; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    cyc = 0;
    while (!done8 && cyc < 40) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start8 = 1'b0;
    a = '0; b = '0; a8 = '0; b8 = '0;
    tick(); tick();
    n_cmp++;
    if ({q, r, done, busy, dbz, state_out, count_out} !== '0) begin
      n_err++;
      $display("FAIL reset128: q=%0h r=%0h done=%b busy=%b dbz=%b st=%0d cnt=%0d want all 0",
               q, r, done, busy, dbz, state_out, count_out);
    end
    n_cmp++;
    if ({q8, r8, done8, busy8, dbz8, state8, count8} !== '0) begin
      n_err++;
      $display("FAIL reset8: q=%0h r=%0h done=%b st=%0d want all 0", q8, r8, done8, state8);
    end
    #2 reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int bad = 0;
    a = 128'd100; b = 128'd7; start = 1'b1;
    tick();
    start = 1'b0;
    n_cmp++;
    if (state_out !== 2'd1 || count_out !== 7'd127 || busy !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_edge0: st=%0d cnt=%0d busy=%b done=%b want 1/127/1/0",
               state_out, count_out, busy, done);
    end
    for (int k = 1; k < N; k++) begin
      tick();
      if (state_out !== 2'd1 || count_out !== 7'(N - 1 - k) || busy !== 1'b1 || done !== 1'b0)
        bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL basic_run: %0d run cycles wrong state/count, want 0", bad);
    end
    tick();
    n_cmp++;
    if (state_out !== 2'd2 || done !== 1'b1 || busy !== 1'b0 || count_out !== 7'd0) begin
      n_err++;
      $display("FAIL basic_done_timing: st=%0d done=%b busy=%b cnt=%0d want 2/1/0/0",
               state_out, done, busy, count_out);
    end
    n_cmp++;
    if (q !== 128'd14 || r !== 128'd2 || dbz !== 1'b0) begin
      n_err++;
      $display("FAIL basic_result: q=%0d r=%0d dbz=%b want 14/2/0", q, r, dbz);
    end
  endtask

  task automatic test_corners();
    logic [N-1:0] ta[3], tb[3], eq[3], er[3];
    int cyc;
    ta[0] = '1;       tb[0] = 128'd1;  eq[0] = '1;      er[0] = '0;
    ta[1] = '1;       tb[1] = '1;      eq[1] = 128'd1;  er[1] = '0;
    ta[2] = 128'd5;   tb[2] = 128'd9;  eq[2] = '0;      er[2] = 128'd5;
    for (int i = 0; i < 3; i++) begin
      do_op128(ta[i], tb[i], cyc);
      n_cmp++;
      if (cyc != N || q !== eq[i] || r !== er[i]) begin
        n_err++;
        $display("FAIL corner%0d: cyc=%0d q=%0h r=%0h want %0d/%0h/%0h", i, cyc, q, r, N, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_div_zero();
    int cyc;
    do_op128(128'd1234, '0, cyc);
    n_cmp++;
    if (cyc != 1 || q !== {N{1'b1}} || r !== 128'd1234 || dbz !== 1'b1) begin
      n_err++;
      $display("FAIL div_zero: cyc=%0d q=%0h r=%0d dbz=%b want 1/all-ones/1234/1", cyc, q, r, dbz);
    end
    do_op128(128'd10, 128'd3, cyc);
    n_cmp++;
    if (cyc != N || q !== 128'd3 || r !== 128'd1 || dbz !== 1'b0) begin
      n_err++;
      $display("FAIL div_zero_clear: cyc=%0d q=%0d r=%0d dbz=%b want %0d/3/1/0", cyc, q, r, dbz, N);
    end
  endtask

  task automatic test_reset_mid_run();
    int cyc;
    a = 128'd999999; b = 128'd13; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 60; k++) tick();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({q, r, done, busy, dbz, state_out, count_out} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_run: q=%0h r=%0h done=%b busy=%b st=%0d cnt=%0d want all 0",
               q, r, done, busy, state_out, count_out);
    end
    #3 reset = 1'b0;
    tick();
    do_op128(128'd1000, 128'd33, cyc);
    n_cmp++;
    if (cyc != N || q !== 128'd30 || r !== 128'd10) begin
      n_err++;
      $display("FAIL after_reset: cyc=%0d q=%0d r=%0d want %0d/30/10", cyc, q, r, N);
    end
  endtask

  task automatic test_ignore_and_back_to_back();
    logic [N-1:0] av, bv, av2, bv2;
    int cyc, low;
    av = rand128(); bv = {64'd0, $urandom, $urandom} | 128'd1;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 40; k++) tick();
    a = rand128(); b = 128'd3; start = 1'b1;
    tick(); tick();
    start = 1'b0;
    cyc = 42;
    while (!done && cyc < 300) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (cyc != N || q !== av / bv || r !== av % bv) begin
      n_err++;
      $display("FAIL ignore_mid_run: cyc=%0d q=%0h r=%0h want %0d/%0h/%0h", cyc, q, r, N, av / bv, av % bv);
    end
    // Start held high in DONE: done drops for exactly N sampled cycles per result.
    av2 = rand128(); bv2 = rand128() >> 70;
    if (bv2 == '0) bv2 = 128'd5;
    a = av2; b = bv2; start = 1'b1;
    tick();
    low = 0;
    while (!done && low < 300) begin
      low++;
      tick();
    end
    n_cmp++;
    if (low != N || q !== av2 / bv2 || r !== av2 % bv2) begin
      n_err++;
      $display("FAIL back_to_back1: low=%0d q=%0h r=%0h want %0d/%0h/%0h", low, q, r, N, av2 / bv2, av2 % bv2);
    end
    a = av; b = bv;
    tick();
    low = 0;
    while (!done && low < 300) begin
      low++;
      tick();
    end
    start = 1'b0;
    n_cmp++;
    if (low != N || q !== av / bv || r !== av % bv) begin
      n_err++;
      $display("FAIL back_to_back2: low=%0d q=%0h r=%0h want %0d/%0h/%0h", low, q, r, N, av / bv, av % bv);
    end
  endtask

  task automatic test_random128();
    logic [N-1:0] av, bv;
    int cyc;
    for (int i = 0; i < 12; i++) begin
      av = rand128();
      bv = rand128() >> $urandom_range(0, 127);
      if (bv == '0) bv = 128'd1;
      do_op128(av, bv, cyc);
      n_cmp++;
      if (cyc != N || q !== av / bv || r !== av % bv || q * bv + r !== av || r >= bv) begin
        n_err++;
        $display("FAIL random128_%0d: a=%0h b=%0h q=%0h r=%0h want q=%0h r=%0h", i, av, bv, q, r, av / bv, av % bv);
      end
    end
  endtask

  task automatic test_n8();
    logic [7:0] av, bv, eq, er;
    int cyc, bad, expc;
    bad = 0;
    for (int bi = 0; bi < 256; bi++) begin
      for (int j = 0; j < 3; j++) begin
        bv = 8'(bi);
        case (j)
          0: av = 8'($urandom_range(0, 255));
          1: av = bv;
          default: av = bv - 8'd1;
        endcase
        if (bv == 8'd0) begin
          eq = 8'hFF; er = av; expc = 1;
        end else begin
          eq = av / bv; er = av % bv; expc = 8;
        end
        do_op8(av, bv, cyc);
        if (cyc != expc || q8 !== eq || r8 !== er || dbz8 !== (bv == 8'd0) ||
            (bv != 8'd0 && (16'(q8) * 16'(bv) + 16'(r8) != 16'(av) || r8 >= bv))) begin
          bad++;
          if (bad < 5)
            $display("FAIL n8: a=%0d b=%0d cyc=%0d q=%0d r=%0d want %0d/%0d/%0d", av, bv, cyc, q8, r8, expc, eq, er);
        end
      end
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL n8_sweep: %0d bad operations, want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_corners();
    test_div_zero();
    test_reset_mid_run();
    test_ignore_and_back_to_back();
    test_random128();
    test_n8();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
